// File: rtl/exe_stage_pipe_pkg.sv
// Shared encodings for the Y86 execute stage: instruction codes,
// ALU function codes, branch/cmov condition codes and the "no register" ID.
package exe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;

  localparam logic [3:0] C_YES    = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] RNONE    = 4'hF;

endpackage

// File: rtl/exe_stage_pipe_if.sv
// Decode -> execute -> memory bus of the execute stage, including the
// squash/CC-enable controls and the architectural CC flags.
interface exe_stage_pipe_if #(parameter int W = 64);

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic [3:0]   dstE;
  logic [3:0]   dstM;
  logic         flush;
  logic         cc_en;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic [3:0]   out_dstE;
  logic [3:0]   out_dstM;
  logic         out_cnd;
  logic         out_err;
  logic         ZF;
  logic         SF;
  logic         OF;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, dstE, dstM, flush, cc_en, out_ready,
    input  in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_dstM,
           out_cnd, out_err, ZF, SF, OF
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, dstE, dstM, flush, cc_en, out_ready,
    output in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_dstM,
           out_cnd, out_err, ZF, SF, OF
  );

endinterface

// File: rtl/exe_stage_pipe_alu.sv
// Combinational OPq ALU: r = b op a, with the flags the CC register latches.
module exe_alu
  import exe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic [3:0]          fn,
  output logic signed [W-1:0] r,
  output logic                zf,
  output logic                sf,
  output logic                of
);

  // Result and overflow per function; undefined functions yield 0 with no overflow
  always_comb begin
    r  = '0;
    of = 1'b0;
    case (fn)
      ALU_ADD: begin
        r  = b + a;
        of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        r  = b - a;
        of = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
      end
      ALU_AND: r = b & a;
      ALU_XOR: r = b ^ a;
      default: r = '0;
    endcase
    zf = (r == '0);
    sf = r[W-1];
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Y86 execute stage: valE computation, jump/cmov condition against the stored
// CC, CC update for committed OPq, one registered output slot with
// valid/ready handshake and squash.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int W    = 64,
  parameter int STEP = W / 8
) (
  input logic            clk,
  input logic            rst_n,
  exe_stage_pipe_if.slave bus
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  // Condition evaluated against the CC as it stands before this instruction.
  function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic                zf_q, sf_q, of_q;
  logic                vld_p1;
  logic [3:0]          icode_p1, dstE_p1, dstM_p1;
  logic signed [W-1:0] valE_p1, valA_p1;
  logic                cnd_p1, err_p1;

  logic signed [W-1:0] opa_p0, opb_p0, alu_r_p0, valE_p0;
  logic                alu_zf_p0, alu_sf_p0, alu_of_p0;
  logic                in_ready_p0, accept_p0, err_p0, cnd_p0, cc_we_p0, is_cond_p0;
  logic [3:0]          dstE_p0;

  // ---- stage p0: combinational execute on the decode-side inputs ----
  assign opa_p0 = bus.valA;
  assign opb_p0 = bus.valB;

  exe_alu #(.W(W)) u_alu (
    .a  (opa_p0),
    .b  (opb_p0),
    .fn (bus.ifun),
    .r  (alu_r_p0),
    .zf (alu_zf_p0),
    .sf (alu_sf_p0),
    .of (alu_of_p0)
  );

  assign in_ready_p0 = ~vld_p1 | bus.out_ready;
  assign accept_p0   = bus.in_valid & in_ready_p0 & ~bus.flush;
  assign is_cond_p0  = (bus.icode == I_RRMOVQ) || (bus.icode == I_JXX);
  assign err_p0      = (bus.icode > I_POPQ)
                     || ((bus.icode == I_OPQ) && (bus.ifun > ALU_XOR))
                     || (is_cond_p0 && (bus.ifun > C_G));
  assign cnd_p0      = is_cond_p0 ? cond_eval(bus.ifun, zf_q, sf_q, of_q) : 1'b1;
  assign dstE_p0     = ((bus.icode == I_RRMOVQ) && !cnd_p0) ? RNONE : bus.dstE;
  assign cc_we_p0    = accept_p0 && (bus.icode == I_OPQ) && bus.cc_en && !err_p0;

  // Select valE by instruction class
  always_comb begin
    valE_p0 = '0;
    case (bus.icode)
      I_OPQ:               valE_p0 = alu_r_p0;
      I_IRMOVQ:            valE_p0 = bus.valC;
      I_RRMOVQ:            valE_p0 = opa_p0;
      I_RMMOVQ, I_MRMOVQ:  valE_p0 = opb_p0 + bus.valC;
      I_CALL, I_PUSHQ:     valE_p0 = opb_p0 - STEP_W;
      I_RET, I_POPQ:       valE_p0 = opb_p0 + STEP_W;
      default:             valE_p0 = '0;
    endcase
  end

  // ---- stage p1: architectural CC and output register ----
  // CC register: written only by a committed, error-free OPq with cc_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_we_p0) begin
      zf_q <= alu_zf_p0;
      sf_q <= alu_sf_p0;
      of_q <= alu_of_p0;
    end
  end

  // Output slot: flush empties it, accept loads it, a taken output drains it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      icode_p1 <= '0;
      valE_p1  <= '0;
      valA_p1  <= '0;
      dstE_p1  <= RNONE;
      dstM_p1  <= RNONE;
      cnd_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else if (bus.flush) begin
      vld_p1   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      icode_p1 <= bus.icode;
      valE_p1  <= valE_p0;
      valA_p1  <= opa_p0;
      dstE_p1  <= dstE_p0;
      dstM_p1  <= bus.dstM;
      cnd_p1   <= cnd_p0;
      err_p1   <= err_p0;
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_icode = icode_p1;
  assign bus.out_valE  = valE_p1;
  assign bus.out_valA  = valA_p1;
  assign bus.out_dstE  = dstE_p1;
  assign bus.out_dstM  = dstM_p1;
  assign bus.out_cnd   = cnd_p1;
  assign bus.out_err   = err_p1;
  assign bus.ZF        = zf_q;
  assign bus.SF        = sf_q;
  assign bus.OF        = of_q;

endmodule
